rstin_filter: RTL and testbench
===============================

RSTIN_FILTER -- requirements
Module: rstin_filter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops on btn_n; legal values are 2 or more.
REQ-002 Parameter DB_CYCLES, default 8, SHALL set the consecutive stable samples needed to accept a level change; legal values are 2 or more.
REQ-003 Parameter HOLD_CYCLES, default 16, SHALL set the minimum ASSERT-state dwell, in cycles; legal values are 1 or more.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 btn_n  input  1  SHALL be the raw board reset button, active-low, asynchronous and bouncing.
REQ-007 rstin_n  output  1  SHALL be the filtered, active-low reset request that feeds the global reset generator.
REQ-008 pressed  output  1  SHALL be a one-cycle pulse marking each accepted press.
REQ-009 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-010 btn_n SHALL pass through SYNC_STAGES flops before use; btn_s is the last stage; all synchronizer flops SHALL reset to 1.
REQ-011 The block SHALL implement the states IDLE, DEB_ON, ASSERT and DEB_OFF; all outputs SHALL be registered.
REQ-012 IDLE: rstin_n=1; btn_s=0 -> DEB_ON with debounce counter cleared.
REQ-013 DEB_ON: btn_s=1 -> IDLE (bounce rejected); DB_CYCLES consecutive btn_s=0 samples, counting the one that left IDLE -> ASSERT.
REQ-014 On the DEB_ON->ASSERT edge, rstin_n SHALL go 0 and pressed SHALL be 1 for exactly one cycle.
REQ-015 Latency from a clean btn_n fall to rstin_n=0 SHALL be exactly SYNC_STAGES+DB_CYCLES rising edges (10 with defaults); the same latency SHALL apply from a clean btn_n rise to rstin_n=1, provided the hold is met.
REQ-016 ASSERT: rstin_n=0; a hold counter SHALL count dwell cycles and saturate at HOLD_CYCLES.
REQ-017 ASSERT SHALL move to DEB_OFF only when the hold counter equals HOLD_CYCLES and btn_s=1.
REQ-018 DEB_OFF: rstin_n=0; btn_s=0 -> ASSERT with hold counter retained (saturated) and debounce counter cleared.
REQ-019 DEB_OFF: DB_CYCLES consecutive btn_s=1 samples -> IDLE, with rstin_n=1 on that edge.
REQ-020 The minimum rstin_n low time SHALL be HOLD_CYCLES+DB_CYCLES cycles (24 with defaults), regardless of press length.
REQ-021 Counter widths SHALL be sized with clog2 of their parameter plus 1; counters SHALL NOT wrap and SHALL saturate at their terminal value.
REQ-022 pressed SHALL NOT re-pulse until the FSM has returned to IDLE and a new press has been debounced.

Reset
REQ-023 While rst=1 at a rising edge, the FSM SHALL go to IDLE, all counters SHALL clear to 0 and all synchronizer flops SHALL be set to 1.
REQ-024 Reset output values SHALL be rstin_n=1, pressed=0 and busy=0, all visible after the first edge with rst=1.
REQ-025 rst SHALL take priority over every transition, including mid-ASSERT.
REQ-026 If btn_n is still held low after rst falls, the press SHALL be re-accepted only after the full SYNC_STAGES+DB_CYCLES latency measured from the first edge with rst=0.

Verification (defaults SYNC_STAGES=2, DB_CYCLES=8, HOLD_CYCLES=16)
REQ-027 Clean press: btn_n low for 40 cycles then high -> rstin_n falls 10 edges after the fall and rises 10 edges after the release; pressed is high for exactly the single cycle in which rstin_n first reads 0.
REQ-028 Bounce reject: btn_n toggles low 5 cycles / high 1 cycle for 60 cycles -> rstin_n stays 1, pressed stays 0, busy toggles.
REQ-029 Short press: btn_n low for 12 cycles -> rstin_n is low for exactly 24 consecutive cycles, with one pressed pulse.
REQ-030 Release glitch: during DEB_OFF, btn_n goes low for 1 cycle then high -> rstin_n stays 0, and rises DB_CYCLES edges after btn_s is stable high again (no second pressed pulse).
REQ-031 Reset mid-assert: rst=1 for 1 cycle while rstin_n=0 and btn_n is held low -> rstin_n=1 on the next edge, then rstin_n=0 again 10 edges after rst returns to 0.
REQ-032 Power-on: rst=1 with btn_n=0 -> rstin_n=1 and busy=0 throughout reset; no pressed pulse until 10 edges after rst is released.

Source files
------------

// File: rtl/rstin_filter.sv
// rstin_filter: turns a raw, bouncing, active-low board reset button into a
// clean active-low reset request for the global reset generator.
// The button is synchronised first and then debounced in both directions.
// Once a press is accepted, rstin_n stays low for a guaranteed minimum time.
// Outputs: rstin_n (filtered request), pressed (one-cycle pulse per press),
// busy (high whenever the filter is not idle).
module rstin_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic rstin_n,
    output logic pressed,
    output logic busy
);

    localparam int DB_W   = $clog2(DB_CYCLES) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;

    // Count value at which the DB_CYCLES-th consecutive sample is seen.
    // The sample that enters a debounce state is the first, with the count
    // still at zero, so the terminal count is DB_CYCLES-2.
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 2);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEB_ON,
        ST_ASSERT,
        ST_DEB_OFF
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   btn_s;
    state_t                 state_reg;
    logic [DB_W-1:0]        db_cnt_reg;
    logic [HOLD_W-1:0]      hold_cnt_reg;
    logic                   rstin_n_reg;
    logic                   pressed_reg;
    logic                   busy_reg;

    // Synchroniser chain. Each stage idles at 1, the released level of the button.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage samples the asynchronous button pin.
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b1;
                    else     sync_reg[gi] <= btn_n;
                end
            end else begin : g_rest
                // Later stages shift the sample along the chain.
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b1;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign btn_s = sync_reg[SYNC_STAGES-1];

    // Debounce and hold FSM. Every output is registered next to its state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            db_cnt_reg   <= '0;
            hold_cnt_reg <= '0;
            rstin_n_reg  <= 1'b1;
            pressed_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            pressed_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!btn_s) begin
                        state_reg  <= ST_DEB_ON;
                        db_cnt_reg <= '0;
                        busy_reg   <= 1'b1;
                    end
                end
                ST_DEB_ON: begin
                    if (btn_s) begin
                        // Bounce: the press did not stay low long enough.
                        state_reg  <= ST_IDLE;
                        db_cnt_reg <= '0;
                        busy_reg   <= 1'b0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg    <= ST_ASSERT;
                        db_cnt_reg   <= '0;
                        hold_cnt_reg <= '0;
                        rstin_n_reg  <= 1'b0;
                        pressed_reg  <= 1'b1;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (hold_cnt_reg == HOLD_MAX && btn_s) begin
                        state_reg  <= ST_DEB_OFF;
                        db_cnt_reg <= '0;
                    end else if (hold_cnt_reg != HOLD_MAX) begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                ST_DEB_OFF: begin
                    if (!btn_s) begin
                        // A release glitch returns to ASSERT. The hold count
                        // stays saturated, so no new minimum dwell is imposed.
                        state_reg  <= ST_ASSERT;
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg    <= ST_IDLE;
                        db_cnt_reg   <= '0;
                        hold_cnt_reg <= '0;
                        rstin_n_reg  <= 1'b1;
                        busy_reg     <= 1'b0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    db_cnt_reg  <= '0;
                    rstin_n_reg <= 1'b1;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign rstin_n = rstin_n_reg;
    assign pressed = pressed_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_rstin_filter.sv
// Directed bench for rstin_filter with default parameters.
// Expected rstin_n edges are queued as each stimulus step is driven, with the
// clock cycle at which each edge must appear.
// A negedge monitor pops an entry on every observed edge and checks its cycle,
// its level and the pressed pulse that must come with a falling edge.
module tb_rstin_filter;

    logic clk = 1'b0;
    logic rst;
    logic btn_n;
    logic rstin_n;
    logic pressed;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int pulse_cnt = 0;

    typedef struct {
        int    cyc;
        logic  val;
        string tag;
    } ev_t;

    ev_t exp_q[$];

    rstin_filter #(
        .SYNC_STAGES(2),
        .DB_CYCLES  (8),
        .HOLD_CYCLES(16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_n  (btn_n),
        .rstin_n(rstin_n),
        .pressed(pressed),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; read at the negedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int at, input logic val, input string tag);
        ev_t e;
        e.cyc = at;
        e.val = val;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Output monitor: match each rstin_n edge and pressed pulse to the scoreboard.
    logic prev_rstin = 1'b1;
    always @(negedge clk) begin
        ev_t  e;
        logic fell;
        fell = 1'b0;
        if (rstin_n !== prev_rstin) begin
            fell = (rstin_n === 1'b0);
            $display("edge: cyc=%0d rstin_n=%0b pressed=%0b busy=%0b", cyc, rstin_n, pressed, busy);
            if (exp_q.size() == 0) begin
                check("pending_event", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check({e.tag, "_cyc"}, 32'(cyc), 32'(e.cyc));
                check({e.tag, "_val"}, 32'(rstin_n), 32'(e.val));
                if (e.val == 1'b0) check({e.tag, "_pressed"}, 32'(pressed), 32'd1);
            end
            prev_rstin = rstin_n;
        end
        if (pressed === 1'b1) begin
            pulse_cnt++;
            check("pressed_at_fall", 32'(fell), 32'd1);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check({e.tag, "_missed"}, 32'(cyc), 32'(e.cyc));
        end
    end

    initial begin
        int   n;
        int   p0;
        logic saw0;
        logic saw1;

        // Power-on with the button held: outputs stay quiet throughout reset.
        rst   = 1'b1;
        btn_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("por_rstin_n", 32'(rstin_n), 32'd1);
            check("por_busy",    32'(busy),    32'd0);
            check("por_pressed", 32'(pressed), 32'd0);
        end
        p0 = pulse_cnt;
        n = cyc;
        rst = 1'b0;
        push(n + 10, 1'b0, "por_fall");
        tick(40);
        n = cyc;
        btn_n = 1'b1;
        push(n + 10, 1'b1, "por_rise");
        tick(20);
        check("por_idle_busy", 32'(busy), 32'd0);
        check("por_pulses", 32'(pulse_cnt - p0), 32'd1);
        $display("step: power-on done cyc=%0d", cyc);

        // Clean press of 40 cycles.
        p0 = pulse_cnt;
        n = cyc;
        btn_n = 1'b0;
        push(n + 10, 1'b0, "clean_fall");
        push(n + 50, 1'b1, "clean_rise");
        tick(40);
        btn_n = 1'b1;
        tick(20);
        check("clean_pulses", 32'(pulse_cnt - p0), 32'd1);
        $display("step: clean press done cyc=%0d", cyc);

        // Bounce: low 5 / high 1 never debounces, but busy follows the attempts.
        p0   = pulse_cnt;
        saw0 = 1'b0;
        saw1 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            btn_n = ((i % 6) < 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (busy === 1'b1) saw1 = 1'b1;
            if (busy === 1'b0) saw0 = 1'b1;
        end
        btn_n = 1'b1;
        tick(10);
        check("bounce_busy_high", 32'(saw1), 32'd1);
        check("bounce_busy_low",  32'(saw0), 32'd1);
        check("bounce_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("bounce_rstin_n", 32'(rstin_n), 32'd1);
        check("bounce_idle_busy", 32'(busy), 32'd0);
        $display("step: bounce reject done cyc=%0d", cyc);

        // Short press: rstin_n low for HOLD+DB = 24 cycles.
        p0 = pulse_cnt;
        n = cyc;
        btn_n = 1'b0;
        push(n + 10, 1'b0, "short_fall");
        push(n + 34, 1'b1, "short_rise");
        tick(12);
        btn_n = 1'b1;
        tick(35);
        check("short_pulses", 32'(pulse_cnt - p0), 32'd1);
        $display("step: short press done cyc=%0d", cyc);

        // Release glitch during DEB_OFF delays the rise and gives no second pulse.
        p0 = pulse_cnt;
        n = cyc;
        btn_n = 1'b0;
        push(n + 10, 1'b0, "glitch_fall");
        push(n + 44, 1'b1, "glitch_rise");
        tick(30);
        btn_n = 1'b1;
        tick(3);
        btn_n = 1'b0;
        tick(1);
        btn_n = 1'b1;
        tick(6);
        check("glitch_still_low", 32'(rstin_n), 32'd0);
        tick(14);
        check("glitch_pulses", 32'(pulse_cnt - p0), 32'd1);
        $display("step: release glitch done cyc=%0d", cyc);

        // Reset mid-assert with the button held, then a re-accept after full latency.
        p0 = pulse_cnt;
        n = cyc;
        btn_n = 1'b0;
        push(n + 10, 1'b0, "rstmid_fall1");
        tick(15);
        rst = 1'b1;
        push(n + 16, 1'b1, "rstmid_rise");
        tick(1);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_pressed", 32'(pressed), 32'd0);
        rst = 1'b0;
        push(n + 26, 1'b0, "rstmid_fall2");
        tick(34);
        btn_n = 1'b1;
        push(n + 60, 1'b1, "rstmid_rise2");
        tick(20);
        check("rstmid_pulses", 32'(pulse_cnt - p0), 32'd2);
        $display("step: reset mid-assert done cyc=%0d", cyc);

        tick(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("total_pulses", 32'(pulse_cnt), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
